// File: rtl/layer_sequencer_if.sv
// Bundle of the three streams around a layer sequencer: input vector,
// neuron broadcast/collect, and the serial activation output.
interface layer_sequencer_if #(
    parameter int dataWidth = 16,
    parameter int numNeuron = 30
);
    logic [dataWidth-1:0]           s_data;
    logic                           s_valid;
    logic                           s_ready;
    logic [dataWidth-1:0]           n_data;
    logic                           n_valid;
    logic [numNeuron*dataWidth-1:0] n_out;
    logic [numNeuron-1:0]           n_outvalid;
    logic [dataWidth-1:0]           m_data;
    logic                           m_valid;
    logic                           m_ready;
    logic                           m_last;
    logic                           busy;
    logic                           err;

    // Environment side: upstream producer, the neurons, downstream consumer.
    modport master (
        output s_data, s_valid, n_out, n_outvalid, m_ready,
        input  s_ready, n_data, n_valid, m_data, m_valid, m_last, busy, err
    );

    // Sequencer side.
    modport slave (
        input  s_data, s_valid, n_out, n_outvalid, m_ready,
        output s_ready, n_data, n_valid, m_data, m_valid, m_last, busy, err
    );
endinterface

// File: rtl/layer_sequencer.sv
// Sequencer for one fully-connected layer: broadcasts the input vector to
// all neurons, collects their activations, then replays them serially.
module layer_sequencer #(
    parameter int numInput  = 784,
    parameter int numNeuron = 30,
    parameter int dataWidth = 16,
    parameter int timeout   = 1024
) (
    input logic              clk,
    input logic              rst,
    layer_sequencer_if.slave bus
);
    localparam int CNT_W  = $clog2(numInput + 1);
    localparam int WAIT_W = $clog2(timeout);
    localparam int IDX_W  = (numNeuron > 1) ? $clog2(numNeuron) : 1;

    localparam logic [CNT_W-1:0]  LAST_IN  = CNT_W'(numInput - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(timeout - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(numNeuron - 1);

    typedef enum logic [1:0] {IDLE, FEED, WAIT, DRAIN} state_t;

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       in_cnt, in_cnt_nx;
    logic [WAIT_W-1:0]      wait_cnt, wait_cnt_nx;
    logic [IDX_W-1:0]       idx, idx_nx, idx_inc;
    logic [numNeuron-1:0]   done_mask, done_mask_nx, mask_cap;
    logic [dataWidth-1:0]   act_buf    [numNeuron];
    logic [dataWidth-1:0]   act_buf_nx [numNeuron];
    logic                   err_nx;
    logic                   m_valid_nx, m_last_nx;
    logic [dataWidth-1:0]   m_data_nx;
    logic                   hs, m_hs, capture_en;

    assign hs      = bus.s_valid & bus.s_ready;
    assign m_hs    = bus.m_valid & bus.m_ready;
    assign idx_inc = idx + 1'b1;

    // Merge this cycle's completion pulses into the mask and activation buffer.
    always_comb begin
        capture_en = (state == FEED) || (state == WAIT);
        mask_cap   = done_mask;
        for (int unsigned k = 0; k < numNeuron; k++) begin
            act_buf_nx[k] = act_buf[k];
        end
        if (capture_en) begin
            mask_cap = done_mask | bus.n_outvalid;
            for (int unsigned k = 0; k < numNeuron; k++) begin
                if (bus.n_outvalid[k]) begin
                    act_buf_nx[k] = bus.n_out[k*dataWidth +: dataWidth];
                end
            end
        end
    end

    // Next-state, counter and output-stream decisions.
    always_comb begin
        state_nx     = state;
        in_cnt_nx    = in_cnt;
        wait_cnt_nx  = wait_cnt;
        idx_nx       = idx;
        done_mask_nx = mask_cap;
        err_nx       = bus.err;
        m_valid_nx   = bus.m_valid;
        m_last_nx    = bus.m_last;
        m_data_nx    = bus.m_data;
        unique case (state)
            IDLE: begin
                if (hs) begin
                    in_cnt_nx = CNT_W'(1);
                    state_nx  = (numInput == 1) ? WAIT : FEED;
                end
            end
            FEED: begin
                if (hs) begin
                    in_cnt_nx = in_cnt + 1'b1;
                    if (in_cnt == LAST_IN) state_nx = WAIT;
                end
            end
            WAIT: begin
                wait_cnt_nx = wait_cnt + 1'b1;
                if (&mask_cap) begin
                    // First beat reads the post-capture buffer so a neuron
                    // finishing in this same cycle is already visible.
                    state_nx     = DRAIN;
                    idx_nx       = '0;
                    done_mask_nx = '0;
                    wait_cnt_nx  = '0;
                    m_valid_nx   = 1'b1;
                    m_data_nx    = act_buf_nx[0];
                    m_last_nx    = (LAST_IDX == '0);
                end else if (wait_cnt == WAIT_MAX) begin
                    state_nx     = IDLE;
                    err_nx       = 1'b1;
                    done_mask_nx = '0;
                    wait_cnt_nx  = '0;
                    in_cnt_nx    = '0;
                end
            end
            DRAIN: begin
                if (m_hs) begin
                    if (bus.m_last) begin
                        state_nx   = IDLE;
                        in_cnt_nx  = '0;
                        m_valid_nx = 1'b0;
                        m_last_nx  = 1'b0;
                    end else begin
                        idx_nx    = idx_inc;
                        m_data_nx = act_buf[idx_inc];
                        m_last_nx = (idx_inc == LAST_IDX);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_cnt      <= '0;
            wait_cnt    <= '0;
            idx         <= '0;
            done_mask   <= '0;
            for (int unsigned k = 0; k < numNeuron; k++) act_buf[k] <= '0;
            bus.s_ready <= 1'b0;
            bus.n_valid <= 1'b0;
            bus.n_data  <= '0;
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
            bus.m_data  <= '0;
            bus.busy    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            state       <= state_nx;
            in_cnt      <= in_cnt_nx;
            wait_cnt    <= wait_cnt_nx;
            idx         <= idx_nx;
            done_mask   <= done_mask_nx;
            act_buf     <= act_buf_nx;
            bus.s_ready <= (state_nx == IDLE) || (state_nx == FEED);
            bus.n_valid <= hs;
            if (hs) bus.n_data <= bus.s_data;
            bus.m_valid <= m_valid_nx;
            bus.m_last  <= m_last_nx;
            bus.m_data  <= m_data_nx;
            bus.busy    <= (state_nx != IDLE);
            bus.err     <= err_nx;
        end
    end
endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Controls one fully-connected layer of neurons. It accepts an input vector as a valid/ready stream and broadcasts each element to every neuron of the layer. It then gathers the per-neuron activations as each neuron signals completion, and replays them as a serial valid/ready stream with a last marker, which is the format the next layer's sequencer consumes. It sits between layers in the network pipeline, and a frame timeout flags neurons that never complete.

## Interface
- numInput, 784, elements per input vector (equals each neuron's numWeight); ≥1
- numNeuron, 30, neurons in the layer; ≥1
- dataWidth, 16, element/activation width
- timeout, 1024, max cycles in WAIT before error; ≥16

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_data  in  dataWidth  input element
- s_valid  in  1  input element valid
- s_ready  out  1  sequencer accepts element
- n_data  out  dataWidth  broadcast element to all neuron myinput
- n_valid  out  1  broadcast valid to all neuron myinputValid
- n_out  in  numNeuron*dataWidth  neuron activations, neuron k at bits [k*dataWidth +: dataWidth]
- n_outvalid  in  numNeuron  per-neuron one-cycle completion pulse
- m_data  out  dataWidth  output activation
- m_valid  out  1  output valid
- m_ready  in  1  downstream accepts
- m_last  out  1  marks activation of neuron numNeuron-1
- busy  out  1  high in any state except IDLE
- err  out  1  sticky timeout flag, cleared only by rst

## Operation
- States: IDLE, FEED, WAIT, DRAIN.
- Reset: state=IDLE, all counters 0, done-mask 0, and every output 0.
  - s_ready=0, n_valid=0, n_data=0, m_valid=0, m_last=0, m_data=0, busy=0, err=0.
- IDLE:
  - s_ready=1.
  - The first s_valid&s_ready handshake counts as element 0 and moves to FEED.
  - With numInput=1 it moves directly to WAIT.
- FEED:
  - s_ready=1. Every handshake increments in_cnt (width clog2(numInput+1)).
  - The handshake that makes in_cnt==numInput moves to WAIT. s_ready drops in WAIT.
  - Gaps in s_valid are allowed. n_valid is 0 in gap cycles.
- Broadcast: on each handshake, register n_data<=s_data and n_valid<=1. Otherwise n_valid<=0 and n_data holds its value.
- Capture, active in FEED and WAIT:
  - For each k with n_outvalid[k]=1: buf[k]<=n_out[k], done_mask[k]<=1.
  - Pulses arriving in IDLE or DRAIN are ignored.
  - A repeated pulse from an already-done neuron overwrites buf[k] and is harmless.
- WAIT:
  - wait_cnt increments each cycle.
  - When done_mask is all ones, including the case where the final bits arrive this cycle: move to DRAIN, idx=0, clear done_mask and wait_cnt.
  - Else if wait_cnt==timeout-1: set err=1, clear done_mask and counters, go to IDLE. No output is produced for that frame.
- DRAIN:
  - m_valid=1, m_data=buf[idx], m_last=(idx==numNeuron-1).
  - On m_valid&m_ready, idx increments.
  - The handshake with m_last=1 moves to IDLE and clears in_cnt.
  - m_data is stable while m_valid&!m_ready.
- rst in any state aborts the frame immediately. Neurons must be reset together with this block.

## Timing
- n_valid/n_data trail the accepting handshake by exactly 1 cycle. Back-to-back handshakes give back-to-back n_valid.
- s_ready is a registered decode of state. It falls the cycle after the final handshake.
- m_valid rises 1 cycle after the cycle in which done_mask completes.
- m_data/m_last are registered from buf/idx with zero-wait streaming: one activation per cycle while m_ready=1.
- Minimum frame: numInput handshakes + neuron latency + 1 + numNeuron drain cycles.
- Re-entry: IDLE asserts s_ready the cycle after the last drain handshake.
- No overlap between frames: input of the next vector waits until drain completes.

## Test plan
- numInput=4, numNeuron=3. Feed elements 1,2,3,4 back-to-back; neurons pulse outvalid together with outputs 0x10,0x20,0x30; m_ready=1 -> n_valid high for 4 consecutive cycles carrying 1..4. Output stream is 0x10,0x20,0x30 with m_last on the third beat. busy returns to 0 after it.
- Same config with s_valid gaps (1,0,1,1,0,1) -> exactly 4 n_valid pulses, no spurious n_valid, in_cnt reaches 4. Then WAIT.
- Staggered completion: neuron 2 at t, neuron 0 at t+3, neuron 1 at t+7 -> DRAIN entered at t+8. The captured values are correct for each index.
- Backpressure: m_ready pattern 0,0,1,0,1,1 -> each activation appears exactly once in order. m_data is held during stalls.
- Timeout=16, neuron 1 never pulses -> err=1 16 cycles after WAIT entry, state IDLE, no m_valid. A subsequent good frame drains correctly with err still 1.
- rst asserted mid-FEED after 2 elements -> all outputs 0 the next cycle. A fresh 4-element frame then completes normally.
